// File: rtl/arp_cache_arbiter.sv
// Purpose : shares the single-port ARP cache RAM between the CPU/OPB requester
//           (read/write) and the fabric TX lookup path (read-only, priority).
// Latency : grant at end of IDLE cycle T; write ack in T+2, read ack in T+2+RD_LATENCY.
// Backpr. : one transaction in flight; req/ack handshake, a pending req waits for IDLE.
//
// Ports
//   OPB_Clk, OPB_Rst                 clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wr_data -> cpu_ack, cpu_rd_data   CPU access
//   tx_req/tx_addr                   -> tx_ack, tx_rd_data        TX MAC lookup
//   ram_addr/ram_wr_data/ram_wr_en, ram_rd_data                    ARP cache RAM
//   busy                             high while a transaction is in progress
module arp_cache_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 48,
   parameter int RD_LATENCY   = 1,
   parameter int TX_BURST_MAX = 4
) (
   input  logic              OPB_Clk,
   input  logic              OPB_Rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rd_data,
   input  logic              tx_req,
   input  logic [ADDR_W-1:0] tx_addr,
   output logic              tx_ack,
   output logic [DATA_W-1:0] tx_rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_wr_en,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(TX_BURST_MAX);
   localparam logic [1:0] CNT_LOAD   = 2'(RD_LATENCY - 1);

   state_t            state_q, state_d;
   logic              gnt_tx_q, gnt_tx_d;     // 1 = TX owns the current transaction
   logic              we_q, we_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [3:0]        tx_streak_q, tx_streak_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              cpu_req_eff;

   logic [ADDR_W-1:0] ram_addr_d;
   logic [DATA_W-1:0] ram_wr_data_d;
   logic              ram_wr_en_d;
   logic              cpu_ack_d, tx_ack_d;
   logic [DATA_W-1:0] cpu_rd_data_d, tx_rd_data_d;
   logic              busy_d;

   // The OPB attach keeps its select asserted for one cycle after the ack it
   // just received; that lingering level must not start a second access. The
   // TX lookup engine, in contrast, may legitimately stream back-to-back
   // requests, so its level is always taken at face value.
   assign cpu_req_eff = cpu_req & ~cpu_hold_q;

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q     <= IDLE;
         gnt_tx_q    <= 1'b0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         tx_streak_q <= '0;
         cpu_hold_q  <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
         ram_wr_en   <= 1'b0;
         cpu_ack     <= 1'b0;
         tx_ack      <= 1'b0;
         cpu_rd_data <= '0;
         tx_rd_data  <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_tx_q    <= gnt_tx_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         tx_streak_q <= tx_streak_d;
         cpu_hold_q  <= cpu_hold_d;
         ram_addr    <= ram_addr_d;
         ram_wr_data <= ram_wr_data_d;
         ram_wr_en   <= ram_wr_en_d;
         cpu_ack     <= cpu_ack_d;
         tx_ack      <= tx_ack_d;
         cpu_rd_data <= cpu_rd_data_d;
         tx_rd_data  <= tx_rd_data_d;
         busy        <= busy_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      gnt_tx_d      = gnt_tx_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      tx_streak_d   = tx_streak_q;
      cpu_hold_d    = 1'b0;
      ram_addr_d    = ram_addr;
      ram_wr_data_d = ram_wr_data;
      ram_wr_en_d   = 1'b0;
      cpu_ack_d     = 1'b0;
      tx_ack_d      = 1'b0;
      cpu_rd_data_d = cpu_rd_data;
      tx_rd_data_d  = tx_rd_data;

      case (state_q)
         IDLE: begin
            if (!cpu_req_eff) begin
               tx_streak_d = '0;
            end
            // TX wins unless it has already taken TX_BURST_MAX grants in a row
            // while the CPU was waiting.
            if (tx_req && (!cpu_req_eff || (tx_streak_q != STREAK_MAX))) begin
               gnt_tx_d   = 1'b1;
               we_d       = 1'b0;
               ram_addr_d = tx_addr;
               state_d    = ISSUE;
               if (cpu_req_eff && (tx_streak_q < STREAK_MAX)) begin
                  tx_streak_d = tx_streak_q + 4'd1;
               end
            end else if (cpu_req_eff) begin
               gnt_tx_d    = 1'b0;
               we_d        = cpu_we;
               ram_addr_d  = cpu_addr;
               ram_wr_en_d = cpu_we;
               if (cpu_we) begin
                  ram_wr_data_d = cpu_wr_data;
               end
               tx_streak_d = '0;
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            if (we_q) begin
               // only the CPU can own a write
               cpu_ack_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (cnt_q == 2'd0) begin
               if (gnt_tx_q) begin
                  tx_rd_data_d = ram_rd_data;
                  tx_ack_d     = 1'b1;
               end else begin
                  cpu_rd_data_d = ram_rd_data;
                  cpu_ack_d     = 1'b1;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         DONE: begin
            cpu_hold_d = ~gnt_tx_q;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule
